// File: rtl/leb128_fetch_if.sv
// Request/response handshake and genrom window port for the LEB128 immediate fetch stage.
// Both handshakes use valid/ready: a transfer happens on a rising edge with valid && ready high.
interface leb128_fetch_if #(
   parameter int AW    = 4,
   parameter int EXTRA = 4
) ();
   localparam int DW = 8 * (2 ** EXTRA);

   logic              req_valid;
   logic              req_ready;
   logic [AW:0]       req_addr;
   logic              req_signed;
   logic [AW:0]       upper_bound;

   logic [AW:0]       rom_addr;
   logic [EXTRA-1:0]  rom_extra;
   logic [DW-1:0]     rom_data;
   logic              rom_error;

   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_value;
   logic [2:0]        resp_len;
   logic [AW:0]       resp_next_addr;
   logic [1:0]        resp_err;

   modport slave (
      input  req_valid, req_addr, req_signed, upper_bound,
      input  rom_data, rom_error, resp_ready,
      output req_ready, rom_addr, rom_extra,
      output resp_valid, resp_value, resp_len, resp_next_addr, resp_err
   );

   modport master (
      output req_valid, req_addr, req_signed, upper_bound,
      output rom_data, rom_error, resp_ready,
      input  req_ready, rom_addr, rom_extra,
      input  resp_valid, resp_value, resp_len, resp_next_addr, resp_err
   );
endinterface

// File: rtl/leb128_fetch.sv
// Fetches a 5-byte genrom window and decodes one varuint32/varint32 immediate from it.
// One request in flight: IDLE -> FETCH -> WAIT -> DONE, response held until taken.
module leb128_fetch #(
   parameter int AW    = 4,
   parameter int EXTRA = 4,
   parameter int RW    = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   leb128_fetch_if.slave   bus,
   output logic [1:0]      dbg_state
);
   localparam int DW = 8 * (2 ** EXTRA);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

   state_t          state, state_nxt;
   logic            accept;
   logic [AW:0]     addr_q;
   logic [AW:0]     ub_q;
   logic            signed_q;

   logic [7:0]      win [5];
   logic [4:0]      in_bounds;
   logic            found, oob, overlong;
   logic [2:0]      dec_len;
   logic [RW-1:0]   raw_value;
   logic [1:0]      dec_err;
   logic [RW-1:0]   dec_value;
   logic [2:0]      dec_len_out;
   logic [AW:0]     dec_next;

   // Window bytes above byte 4 never belong to a LEB128 encoding.
   logic unused_rom_hi;
   assign unused_rom_hi = ^bus.rom_data[DW-1:40];

   assign accept = bus.req_valid && bus.req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_WAIT;
         S_WAIT:  state_nxt = S_DONE;
         S_DONE:  if (bus.resp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready  = rst_n && (state == S_IDLE);
      bus.resp_valid = (state == S_DONE);
      dbg_state      = state;
   end

   // Terminator search stops at the first out-of-bounds byte, so bytes past
   // upper_bound can never influence length, value or overlong checks.
   always_comb begin
      found     = 1'b0;
      oob       = 1'b0;
      overlong  = 1'b0;
      dec_len   = 3'd0;
      raw_value = '0;
      for (int k = 0; k < 5; k++) begin
         win[k]       = bus.rom_data[(4-k)*8 +: 8];
         in_bounds[k] = ({1'b0, addr_q} + (AW+2)'(k)) <= {1'b0, ub_q};
      end
      for (int k = 0; k < 5; k++) begin
         if (!found && !oob) begin
            if (!in_bounds[k])    oob = 1'b1;
            else if (!win[k][7]) begin
               found   = 1'b1;
               dec_len = 3'(k + 1);
            end
         end
      end
      for (int k = 0; k < 5; k++) begin
         if (found && (k < int'(dec_len))) raw_value = raw_value | (RW'(win[k][6:0]) << (7*k));
      end
      for (int k = 0; k < 4; k++) begin
         if (found && signed_q && (k == int'(dec_len) - 1) && win[k][6])
            raw_value = raw_value | ({RW{1'b1}} << (7*(k+1)));
      end
      if (found && dec_len == 3'd5) begin
         if (signed_q) overlong = (win[4][6:3] != {4{win[4][3]}});
         else          overlong = (win[4][6:4] != 3'd0);
      end
      if (!found && !oob) overlong = 1'b1;

      if (bus.rom_error) dec_err = 2'd1;
      else if (oob)      dec_err = 2'd2;
      else if (overlong) dec_err = 2'd3;
      else               dec_err = 2'd0;

      if (dec_err != 2'd0) begin
         dec_value   = '0;
         dec_len_out = 3'd0;
         dec_next    = addr_q;
      end else begin
         dec_value   = raw_value;
         dec_len_out = dec_len;
         dec_next    = addr_q + (AW+1)'(dec_len);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q             <= '0;
         ub_q               <= '0;
         signed_q           <= 1'b0;
         bus.rom_addr       <= '0;
         bus.rom_extra      <= '0;
         bus.resp_value     <= '0;
         bus.resp_len       <= '0;
         bus.resp_next_addr <= '0;
         bus.resp_err       <= '0;
      end else begin
         if (accept) begin
            addr_q        <= bus.req_addr;
            ub_q          <= bus.upper_bound;
            signed_q      <= bus.req_signed;
            bus.rom_addr  <= bus.req_addr;
            bus.rom_extra <= EXTRA'(4);
         end
         if (state == S_WAIT) begin
            bus.resp_value     <= dec_value;
            bus.resp_len       <= dec_len_out;
            bus.resp_next_addr <= dec_next;
            bus.resp_err       <= dec_err;
         end
         if (state == S_DONE && bus.resp_ready) bus.rom_extra <= '0;
      end
   end
endmodule

// File: tb/tb_leb128_fetch.sv
// Directed bench for leb128_fetch with a registered genrom model and an expected-response queue.
module tb_leb128_fetch;
   localparam int AW    = 4;
   localparam int EXTRA = 4;
   localparam int DW    = 8 * (2 ** EXTRA);

   logic        clk;
   logic        rst_n;
   logic [1:0]  dbg_state;
   logic [7:0]  rom_mem [32];

   int n_checks = 0;
   int n_fail   = 0;
   logic [41:0] exp_q [$];

   leb128_fetch_if #(.AW(AW), .EXTRA(EXTRA)) bus ();

   leb128_fetch #(.AW(AW), .EXTRA(EXTRA), .RW(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // genrom model: registered window read, bytes past upper_bound read as FF.
   function automatic logic [DW-1:0] window(input logic [AW:0] a, input logic [AW:0] ub);
      logic [DW-1:0] w;
      logic [AW+1:0] idx;
      w = '0;
      for (int k = 0; k < 5; k++) begin
         idx = {1'b0, a} + (AW+2)'(k);
         if (idx > {1'b0, ub}) w[(4-k)*8 +: 8] = 8'hFF;
         else                  w[(4-k)*8 +: 8] = rom_mem[idx[AW:0]];
      end
      return w;
   endfunction

   always @(posedge clk) begin
      bus.rom_data  <= window(bus.rom_addr, bus.upper_bound);
      bus.rom_error <= (bus.rom_addr > bus.upper_bound);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load_image(input logic [7:0] b0, b1, b2, b3, b4);
      for (int i = 0; i < 32; i++) rom_mem[i] = 8'hFF;
      rom_mem[0] = b0; rom_mem[1] = b1; rom_mem[2] = b2; rom_mem[3] = b3; rom_mem[4] = b4;
   endtask

   task automatic send_req(input string tag, input logic [AW:0] a, input logic s);
      int n;
      n = 0;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_addr   = a;
      bus.req_signed = s;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, ".accept_wait"}, n, 0);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic run_case(input string tag, input logic [AW:0] a, input logic s,
                           input logic [31:0] ev, input logic [2:0] el,
                           input logic [AW:0] en, input logic [1:0] ee, input int stall);
      int cycles;
      logic [41:0] exp;
      exp_q.push_back({ev, el, en, ee});
      bus.resp_ready = (stall == 0);
      send_req(tag, a, s);
      check_eq({tag, ".rom_extra"}, 32'(bus.rom_extra), 4);
      check_eq({tag, ".rom_addr"}, 32'(bus.rom_addr), 32'(a));
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
      end while (!bus.resp_valid && cycles < 20);
      check_eq({tag, ".latency"}, cycles, 2);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check_eq({tag, ".value"}, bus.resp_value, exp[41:10]);
      check_eq({tag, ".len"},   32'(bus.resp_len), 32'(exp[9:7]));
      check_eq({tag, ".next"},  32'(bus.resp_next_addr), 32'(exp[6:2]));
      check_eq({tag, ".err"},   32'(bus.resp_err), 32'(exp[1:0]));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         check_eq({tag, ".hold_valid"}, 32'(bus.resp_valid), 1);
         check_eq({tag, ".hold_ready"}, 32'(bus.req_ready), 0);
         check_eq({tag, ".hold_value"}, bus.resp_value, exp[41:10]);
         check_eq({tag, ".hold_len"},   32'(bus.resp_len), 32'(exp[9:7]));
         check_eq({tag, ".hold_next"},  32'(bus.resp_next_addr), 32'(exp[6:2]));
      end
      @(negedge clk);
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq({tag, ".valid_drop"}, 32'(bus.resp_valid), 0);
      check_eq({tag, ".ready_back"}, 32'(bus.req_ready), 1);
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.req_valid   = 1'b0;
      bus.req_addr    = '0;
      bus.req_signed  = 1'b0;
      bus.resp_ready  = 1'b1;
      bus.upper_bound = 5'd9;
      load_image(8'h81, 8'h00, 8'h82, 8'h00, 8'h84);
      rom_mem[5] = 8'h00; rom_mem[6] = 8'h88; rom_mem[7] = 8'h00;
      rom_mem[8] = 8'h81; rom_mem[9] = 8'h40;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst.req_ready",  32'(bus.req_ready), 0);
      check_eq("rst.resp_valid", 32'(bus.resp_valid), 0);
      check_eq("rst.rom_extra",  32'(bus.rom_extra), 0);
      check_eq("rst.resp_value", bus.resp_value, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rst.ready_after", 32'(bus.req_ready), 1);

      run_case("a0_u",  5'd0,  1'b0, 32'h1,        3'd1 + 3'd1, 5'd2,  2'd0, 0);
      run_case("a8_u",  5'd8,  1'b0, 32'h2001,     3'd2, 5'd10, 2'd0, 0);
      run_case("a8_s",  5'd8,  1'b1, 32'hFFFFE001, 3'd2, 5'd10, 2'd0, 0);
      run_case("a1_u",  5'd1,  1'b0, 32'h0,        3'd1, 5'd2,  2'd0, 0);
      run_case("a7_u",  5'd7,  1'b0, 32'h0,        3'd1, 5'd8,  2'd0, 0);
      run_case("a10",   5'd10, 1'b0, 32'h0,        3'd0, 5'd10, 2'd1, 0);
      bus.upper_bound = 5'd8;
      run_case("bound", 5'd8,  1'b0, 32'h0,        3'd0, 5'd8,  2'd2, 0);
      bus.upper_bound = 5'd9;
      run_case("bp",    5'd2,  1'b0, 32'h2,        3'd2, 5'd4,  2'd0, 5);

      // Reset dropped while the ROM read is in flight.
      send_req("rstw", 5'd0, 1'b0);
      @(posedge clk);
      #1;
      check_eq("rstw.in_wait", 32'(dbg_state), 2);
      rst_n = 1'b0;
      #1;
      check_eq("rstw.resp_valid", 32'(bus.resp_valid), 0);
      check_eq("rstw.resp_value", bus.resp_value, 0);
      check_eq("rstw.resp_len",   32'(bus.resp_len), 0);
      check_eq("rstw.resp_next",  32'(bus.resp_next_addr), 0);
      check_eq("rstw.resp_err",   32'(bus.resp_err), 0);
      check_eq("rstw.rom_addr",   32'(bus.rom_addr), 0);
      check_eq("rstw.rom_extra",  32'(bus.rom_extra), 0);
      check_eq("rstw.req_ready",  32'(bus.req_ready), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rstw.ready_after", 32'(bus.req_ready), 1);
      check_eq("rstw.no_resp",     32'(bus.resp_valid), 0);
      run_case("post_rst", 5'd2, 1'b0, 32'h2, 3'd2, 5'd4, 2'd0, 0);

      load_image(8'h80, 8'h80, 8'h80, 8'h80, 8'h10);
      run_case("ovl_big", 5'd0, 1'b0, 32'h0, 3'd0, 5'd0, 2'd3, 0);
      load_image(8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
      run_case("ovl_noterm", 5'd0, 1'b0, 32'h0, 3'd0, 5'd0, 2'd3, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/leb128_fetch.md
Name: leb128_fetch

Overview:
- Consumer stage directly downstream of the bytecode ROM (genrom).
- Given a byte address, it issues one 5-byte window read to the ROM (addr plus extra=4).
- It decodes one unsigned or signed LEB128 immediate (WASM varuint32/varint32) from that window.
- It returns the value, the encoded length and the next address over a valid/ready handshake. The opcode-decode and interpreter stages use it to pull immediates from the bytecode stream.

Parameters:
- AW, 4, ROM address width; all address ports are AW+1 bits, matching genrom.
- EXTRA, 4, genrom extra-port width. ROM data width is 8*2**EXTRA. Must be >=3.
- RW, 32, decoded result width. Fixed at 32; maximum encoding is 5 bytes.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block idle; request accepted when req_valid&&req_ready
- req_addr  in  AW+1  address of first LEB128 byte
- req_signed  in  1  1=varint32 (sign-extend), 0=varuint32
- upper_bound  in  AW+1  last legal byte address; same value as fed to genrom
- rom_addr  out  AW+1  genrom addr
- rom_extra  out  EXTRA  genrom extra; constant 4 while reading
- rom_data  in  8*2**EXTRA  genrom data; byte k of the window (k=0..4) at bits [(4-k)*8+7:(4-k)*8]
- rom_error  in  1  genrom error (rom_addr out of range)
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer takes result
- resp_value  out  RW  decoded value
- resp_len  out  3  encoded bytes consumed, 1..5
- resp_next_addr  out  AW+1  req_addr+resp_len, modulo 2**(AW+1)
- resp_err  out  2  0=OK, 1=ROM_ERR, 2=BOUNDS, 3=OVERLONG

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - req_ready=0 while in reset.
  - resp_valid=0; resp_value, resp_len, resp_next_addr, resp_err, rom_addr and rom_extra are all 0.
- FSM states: IDLE, FETCH, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On accept at edge E0: latch req_addr, req_signed and upper_bound; drive rom_addr=req_addr and rom_extra=4; go to FETCH.
- FETCH: rom_addr and rom_extra held. The ROM samples at edge E1 (one-cycle read latency). Go to WAIT.
- WAIT:
  - rom_data and rom_error are valid this cycle.
  - The decode is computed combinationally and registered at E2 into the resp_* registers.
  - Go to DONE.
- DONE:
  - resp_valid=1. All resp_* outputs are held stable until resp_valid&&resp_ready.
  - On that edge go to IDLE; resp_valid drops next cycle.
- Timing:
  - Latency is 2 cycles from the accept edge to resp_valid high.
  - req_ready is 0 outside IDLE, so there is no overlap; minimum request period is 4 cycles.
- Decode:
  - Length n = index of the first byte with bit7=0, plus 1, searched over bytes 0..4.
  - value = sum of byte[k][6:0]<<(7k) for k<n.
  - If req_signed and byte[n-1][6]=1: sign-extend from bit 7n-1; n=5 needs no extension.
- Error priority, 1 > 2 > 3:
  - ROM_ERR: rom_error=1.
  - BOUNDS: req_addr+n-1 > upper_bound, computed at AW+2 bits, no wrap. Also BOUNDS if no terminator exists among the in-bounds bytes. Bytes beyond upper_bound may be X and must never reach resp_value.
  - OVERLONG:
    - No terminator within 5 bytes.
    - Unsigned with byte4[6:4]!=0.
    - Signed with byte4[6:3] not all equal to byte4[3].
- On any error: resp_value=0, resp_len=0, resp_next_addr=req_addr.
- Reset asserted in FETCH, WAIT or DONE aborts the operation immediately; the pending response is lost.
- resp_ready high outside DONE is ignored.

Test Plan:
ROM image bytes 81 00 82 00 84 00 88 00 81 40, upper_bound=9. Each case checks resp_* at resp_valid.
- addr=0, unsigned -> value=1, len=2, next=2, err=0. resp_valid high exactly 2 cycles after the accept edge; rom_extra=4 during FETCH.
- addr=8, unsigned -> value=0x2001, len=2, next=10, err=0. Same request with signed=1 -> value=0xFFFFE001, err=0.
- addr=1, unsigned -> value=0, len=1, next=2. addr=7 -> value=0, len=1, next=8.
- addr=10 -> err=1 (ROM_ERR), value=0, len=0, next=10. Same with upper_bound=8 and addr=8 -> err=2 (BOUNDS).
- Response backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and all resp_* stable, req_ready=0. resp_ready=1 -> resp_valid low and req_ready high next cycle.
- Drop rst_n during WAIT -> resp_valid=0 and all outputs 0 immediately; after release req_ready=1; a fresh addr=2 request -> value=2, len=2, next=4.
- Separate ROM image 80 80 80 80 10 -> err=3 (OVERLONG).
- Separate ROM image 80 80 80 80 80 -> err=3 (OVERLONG).
